// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation sequencer: ALU code layout,
// operation encodings, result width, sequencer FSM states, result-buffer entry
// layout and the set-bit scan used to walk a command mask.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int RES_W  = 16;
    localparam int CODE_W = 3;

    // Code i of a command mask is {sel, op}; sel=0 arithmetic, sel=1 logic.
    typedef struct packed {
        logic       sel;
        logic [1:0] op;
    } alu_code_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } arith_op_e;

    // OP_NOT inverts ip_data1 only.
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } logic_op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ISSUE   = 2'b01,
        S_WAIT    = 2'b10,
        S_CAPTURE = 2'b11
    } seq_state_e;

    typedef struct packed {
        logic [RES_W-1:0] data;
        alu_code_t        tag;
        logic             last;
    } res_entry_t;

    // Lowest set bit of mask at position >= start.
    // Returns {none, idx}: bit 3 set means no such bit exists.
    function automatic logic [3:0] next_code(input logic [7:0] mask,
                                             input logic [3:0] start);
        logic [3:0] r;
        r = 4'b1000;
        for (int i = 7; i >= 0; i--) begin
            if ((i >= int'(start)) && mask[i]) begin
                r = {1'b0, i[2:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// -----------------------------------------------------------------------------
// alu_res_fifo
// Synchronous first-word-fall-through buffer for captured ALU results.
// The head entry is read straight from the storage registers and forced to
// zero while the buffer is empty, so the result stream shows zeros when idle.
// A push while full is accepted when a pop happens in the same cycle.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (pointers/count only)
//   i_push      write request, i_data written when space is available
//   i_data      {data, tag, last} entry
//   i_pop       consumer takes the head entry
//   o_head      current head entry (zero when empty)
//   o_full      DEPTH entries held
//   o_empty     no entries held
// -----------------------------------------------------------------------------
module alu_res_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  res_entry_t i_data,
    input  logic       i_pop,
    output res_entry_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    res_entry_t     r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Accepts one command {data1, data2, mask}, then runs every ALU code whose
// mask bit is set in ascending order: drive the external ALU, wait
// ALU_LATENCY cycles, capture alu_data_out and queue {data, tag, last} for a
// valid/ready consumer. One command is in flight at a time.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_data1, cmd_data2, cmd_mask  operands and code-select mask
//   alu_arith_logic_sel, alu_operation, alu_ip_data1, alu_ip_data2
//                                   registered ALU drive, changed only on ISSUE
//   alu_data_out                    ALU result
//   res_valid/res_ready             result handshake
//   res_data, res_tag, res_last     buffered result, producing code, final flag
//   busy                            command in progress
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_data1,
    input  logic [7:0]  cmd_data2,
    input  logic [7:0]  cmd_mask,
    output logic        alu_arith_logic_sel,
    output logic [1:0]  alu_operation,
    output logic [7:0]  alu_ip_data1,
    output logic [7:0]  alu_ip_data2,
    input  logic [15:0] alu_data_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [2:0]  res_tag,
    output logic        res_last,
    output logic        busy
);

    seq_state_e  r_state;
    seq_state_e  w_state_nxt;
    logic [7:0]  r_mask;
    logic [7:0]  r_d1;
    logic [7:0]  r_d2;
    logic [2:0]  r_idx;
    logic [2:0]  r_cnt;
    logic        r_alu_sel;
    logic [1:0]  r_alu_op;
    logic [7:0]  r_alu_d1;
    logic [7:0]  r_alu_d2;
    logic [3:0]  w_first;
    logic [3:0]  w_next;
    logic        w_last;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    res_entry_t  w_push_entry;
    res_entry_t  w_head;

    assign w_first = next_code(cmd_mask, 4'd0);
    assign w_next  = next_code(r_mask, {1'b0, r_idx} + 4'd1);
    assign w_last  = w_next[3];
    assign w_pop   = !w_fifo_empty && res_ready;

    // Next-state and push decision
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A zero mask is accepted but produces nothing.
                if (cmd_valid && !w_first[3]) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = (ALU_LATENCY == 0) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!w_fifo_full || w_pop) begin
                    w_push      = 1'b1;
                    w_state_nxt = w_last ? S_IDLE : S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control registers and ALU drive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_alu_sel <= 1'b0;
            r_alu_op  <= '0;
            r_alu_d1  <= '0;
            r_alu_d2  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_mask <= cmd_mask;
                        r_idx  <= w_first[2:0];
                    end
                end
                S_ISSUE: begin
                    r_alu_sel <= r_idx[2];
                    r_alu_op  <= r_idx[1:0];
                    r_alu_d1  <= r_d1;
                    r_alu_d2  <= r_d2;
                    r_cnt     <= 3'(ALU_LATENCY);
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                end
                S_CAPTURE: begin
                    if (w_push && !w_last) begin
                        r_idx <= w_next[2:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand latch
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && cmd_valid) begin
            r_d1 <= cmd_data1;
            r_d2 <= cmd_data2;
        end
    end

    assign w_push_entry = '{data: alu_data_out, tag: alu_code_t'(r_idx), last: w_last};

    alu_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign cmd_ready           = (r_state == S_IDLE);
    assign busy                = (r_state != S_IDLE);
    assign alu_arith_logic_sel = r_alu_sel;
    assign alu_operation       = r_alu_op;
    assign alu_ip_data1        = r_alu_d1;
    assign alu_ip_data2        = r_alu_d2;
    assign res_valid           = !w_fifo_empty;
    assign res_data            = w_head.data;
    assign res_tag             = w_head.tag;
    assign res_last            = w_head.last;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential initiator that drives the combinational ALU (`import_package`) from a command stream and returns its results as a stream. A single accepted command carries two operands and an 8-bit mask of `{arith_logic_sel, operation}` codes. The block steps through every selected code in ascending order, waits for the ALU result to settle, captures it, and buffers it for a downstream consumer through a valid/ready handshake. It sits between the host/test controller and the ALU, replacing hand-timed stimulus with a self-paced sequencer.

## Interface
Parameters:
- `ALU_LATENCY`, 1: cycles from driving ALU inputs to sampling `alu_data_out`; legal range 0–7 (0 = same-cycle sample).
- `FIFO_DEPTH`, 4: result buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_data1`  in  8  operand 1.
- `cmd_data2`  in  8  operand 2.
- `cmd_mask`  in  8  bit i set = run code i, where i = {sel, op[1:0]}.
- `alu_arith_logic_sel`  out  1  to ALU.
- `alu_operation`  out  2  to ALU.
- `alu_ip_data1`, `alu_ip_data2`  out  8  to ALU.
- `alu_data_out`  in  16  from ALU.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts.
- `res_data`  out  16  captured ALU result.
- `res_tag`  out  3  code i that produced `res_data`.
- `res_last`  out  1  final result of its command.
- `busy`  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE: `cmd_ready`=1. On handshake, latch the operands and mask.
  - Mask nonzero: set idx = lowest set bit and go to ISSUE.
  - Mask zero: accepted, no results produced, stay in IDLE.
- ISSUE: drive the ALU ports from the latched operands and idx (registered outputs, held until the next ISSUE). Load the wait counter with `ALU_LATENCY`. Go to WAIT, or directly to CAPTURE if `ALU_LATENCY`=0.
- WAIT: decrement the counter; at 1, go to CAPTURE.
- CAPTURE: sample `alu_data_out`.
  - If the FIFO is not full: push {data, tag=idx, last}, where last = no higher set bit remains. Then go to ISSUE with idx = next set bit, or to IDLE if last.
  - If the FIFO is full: stay in CAPTURE, holding the ALU inputs, and push on the first cycle the FIFO is not full.
- `cmd_ready` is low in every state except IDLE; only one command is in flight at a time.
- Result stream: `res_*` reflect the FIFO head. `res_valid`=!empty. Pop on `res_valid && res_ready`. Data is held stable while valid and not ready.
- Simultaneous push and pop when full: the pop frees the slot in the same cycle, so the push proceeds without a stall.
- Reset outputs: `cmd_ready`=1 (IDLE), all ALU outputs 0, `res_valid`=0, `res_data`=0, `res_tag`=0, `res_last`=0, `busy`=0.
- Reset mid-command: the command and all buffered results are discarded; no partial `res_last` is emitted.

## Timing
- Cycles per selected code = 2 + `ALU_LATENCY` (ISSUE + WAIT×L + CAPTURE), plus any full-FIFO stall.
- First `res_valid` rises the cycle after the first CAPTURE push.
- Latency from command accept to first result = 3 + `ALU_LATENCY` cycles with an empty FIFO.
- `cmd_ready` returns high the cycle after the last push.
- ALU inputs change only on the ISSUE edge and are stable throughout WAIT and CAPTURE.

## Structure
- `alu_pkg` holds the shared definitions:
  - Code typedef `alu_code_t` = {logic sel; logic [1:0] op}.
  - Operation enum: arith 00 ADD, 01 SUB, 10 MUL, 11 DIV; logic 00 AND, 01 OR, 10 XOR, 11 NOT(ip_data1).
  - Result width constant 16.
  - FSM state enum.
- Sub-module `alu_res_fifo`: a synchronous FIFO holding {16-bit data, 3-bit tag, last}, with full/empty flags and a registered head. It shares `clk`/`rst_n`.

## Test plan
- Mask 0xFF, operands 20/10, `ALU_LATENCY`=1, `res_ready`=1 → 8 results in tag order 0–7: 30, 10, 200, 2, 0, 30, 30, 0xFFEB. `res_last` is set on tag 7 only, and `cmd_ready` recovers 3 cycles per code after accept.
- Mask 0x0A, operands 60/15 → exactly 2 results: tag 1 = 45, tag 3 = 4 (`res_last` set). No other tags appear.
- `res_ready`=0 with mask 0xFF, `FIFO_DEPTH`=4 → 4 results buffered and the FSM stalls in CAPTURE with ALU inputs stable. After releasing `res_ready`, all 8 results arrive in order with no loss or duplication.
- Mask 0x00 → `cmd_ready` stays 1, `busy` stays 0, and `res_valid` is never asserted.
- Assert `rst_n`=0 for one cycle while on the third code of a 0xFF command → next cycle all outputs are at reset values and the FIFO is empty. A new command then completes normally.
- `ALU_LATENCY`=0 and 3, mask 0x81 → the sampled results match the reference ALU model, with per-code spacing of 2 and 5 cycles respectively.
